// File: rtl/ccu_pkg.sv
// ccu_pkg: shared state encoding, default sizes and counter increment helpers
package ccu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEF_W  = 3;
    localparam int DEF_CH = 4;
    localparam int DEF_CW = 8;
    function automatic logic [31:0] inc_sat(input logic [31:0] v, input logic [31:0] max);
        return v == max ? v : v + 32'd1;
    endfunction
    function automatic logic [31:0] inc_wrap(input logic [31:0] v, input logic [31:0] max);
        return v == max ? 32'd0 : v + 32'd1;
    endfunction
endpackage

// File: rtl/eq_pair_lane.sv
// eq_pair_lane: one channel's comparator, equal-beat count, current/longest run and sticky overflow
module eq_pair_lane
    import ccu_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int CW  = DEF_CW,
    parameter int SAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          beat,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    output logic [CW-1:0] count,
    output logic [CW-1:0] run_max,
    output logic          ovf
);
    localparam logic [31:0] MAX = 32'((64'd1 << CW) - 64'd1);
    logic [CW-1:0] count_q, count_d, run_q, run_d, max_q, max_d;
    logic          ovf_q, ovf_d, hit;
    always_comb begin
        hit     = beat && x == y;
        count_d = clr ? '0 : hit ? (SAT != 0 ? CW'(inc_sat(32'(count_q), MAX)) : CW'(inc_wrap(32'(count_q), MAX))) : count_q;
        ovf_d   = clr ? 1'b0 : ovf_q | (hit && count_q == '1);
        // the run length always saturates so run_max stays meaningful even when count wraps
        run_d   = clr ? '0 : beat ? (hit ? CW'(inc_sat(32'(run_q), MAX)) : '0) : run_q;
        max_d   = clr ? '0 : (hit && run_d > max_q) ? run_d : max_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            run_q   <= '0;
            max_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            run_q   <= run_d;
            max_q   <= max_d;
            ovf_q   <= ovf_d;
        end
    end
    assign count   = count_q;
    assign run_max = max_q;
    assign ovf     = ovf_q;
endmodule

// File: rtl/eq_pair_counter.sv
// eq_pair_counter: windowed per-channel equal-pair counter with start/busy/done control
module eq_pair_counter
    import ccu_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int CH  = DEF_CH,
    parameter int CW  = DEF_CW,
    parameter int SAT = 1,
    parameter int LW  = CW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LW-1:0]    len,
    input  logic             in_valid,
    input  logic [CH*W-1:0]  x,
    input  logic [CH*W-1:0]  y,
    output logic             busy,
    output logic             done,
    output logic [CH*CW-1:0] count,
    output logic [CH*CW-1:0] run_max,
    output logic [CH-1:0]    ovf
);
    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d, beat_q, beat_d;
    logic          clr, beat, last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
        end
    end
    // start is only honoured outside RUN; a zero length window completes on the start edge
    always_comb begin
        clr     = start && state_q != RUN;
        beat    = state_q == RUN && in_valid;
        last    = beat && (beat_q + LW'(1)) == len_q;
        len_d   = clr ? len : len_q;
        beat_d  = clr ? '0 : beat ? beat_q + LW'(1) : beat_q;
        state_d = clr ? (len == '0 ? DONE : RUN) : last ? DONE : state_q;
    end
    always_comb begin
        busy = state_q == RUN;
        done = state_q == DONE;
    end
    for (genvar c = 0; c < CH; c++) begin : g_lane
        eq_pair_lane #(.W(W), .CW(CW), .SAT(SAT)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .beat    (beat),
            .x       (x[c*W +: W]),
            .y       (y[c*W +: W]),
            .count   (count[c*CW +: CW]),
            .run_max (run_max[c*CW +: CW]),
            .ovf     (ovf[c])
        );
    end
endmodule

// File: tb/tb_eq_pair_counter.sv
// tb_eq_pair_counter: scoreboard bench for the default configuration plus two 4-bit overflow instances
module tb_eq_pair_counter;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [7:0]  len = '0;
    logic [11:0] x = '0, y = '0;
    logic [31:0] count, run_max;
    logic [3:0]  ovf;
    logic        busy, done;
    logic [15:0] s_count, s_run_max, w_count, w_run_max;
    logic [3:0]  s_ovf, w_ovf;
    logic        s_busy, s_done, w_busy, w_done;
    eq_pair_counter u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .x(x), .y(y),
        .busy(busy), .done(done), .count(count), .run_max(run_max), .ovf(ovf)
    );
    eq_pair_counter #(.CW(4), .LW(5), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len[4:0]), .in_valid(in_valid), .x(x), .y(y),
        .busy(s_busy), .done(s_done), .count(s_count), .run_max(s_run_max), .ovf(s_ovf)
    );
    eq_pair_counter #(.CW(4), .LW(5), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len[4:0]), .in_valid(in_valid), .x(x), .y(y),
        .busy(w_busy), .done(w_done), .count(w_count), .run_max(w_run_max), .ovf(w_ovf)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] cnt;
        logic [31:0] mx;
        logic [3:0]  ovf;
        logic        busy;
        logic        done;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;
    int m_st = 0, m_len = 0, m_beats = 0;
    int m_cnt[4], m_run[4], m_max[4];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 0;
            m_run[c] = 0;
            m_max[c] = 0;
        end
        m_beats = 0;
    endtask
    task automatic model_step(input bit st, input int ln, input bit v, input logic [11:0] xx, input logic [11:0] yy);
        if (m_st != 1 && st) begin
            model_clear();
            m_len = ln;
            m_st  = ln == 0 ? 2 : 1;
        end else if (m_st == 1 && v) begin
            for (int c = 0; c < 4; c++) begin
                if (xx[c*3 +: 3] == yy[c*3 +: 3]) begin
                    m_cnt[c] = m_cnt[c] == 255 ? 255 : m_cnt[c] + 1;
                    m_run[c] = m_run[c] == 255 ? 255 : m_run[c] + 1;
                    if (m_run[c] > m_max[c]) m_max[c] = m_run[c];
                end else m_run[c] = 0;
            end
            m_beats++;
            if (m_beats == m_len) m_st = 2;
        end
    endtask
    task automatic cycle(input bit st, input int ln, input bit v, input logic [3:0] eqm);
        exp_t e;
        logic [11:0] xx, yy;
        logic [2:0]  r;
        for (int c = 0; c < 4; c++) begin
            r = 3'($urandom_range(0, 7));
            xx[c*3 +: 3] = r;
            yy[c*3 +: 3] = eqm[c] ? r : r ^ 3'd5;
        end
        start = st; len = 8'(ln); in_valid = v; x = xx; y = yy;
        model_step(st, ln, v, xx, yy);
        for (int c = 0; c < 4; c++) begin
            e.cnt[c*8 +: 8] = 8'(m_cnt[c]);
            e.mx[c*8 +: 8]  = 8'(m_max[c]);
        end
        e.ovf  = '0;
        e.busy = m_st == 1;
        e.done = m_st == 2;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("count", count, e.cnt);
        check("run_max", run_max, e.mx);
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("busy", 32'(busy), 32'(e.busy));
        check("done", 32'(done), 32'(e.done));
    endtask
    initial begin
        model_clear();
        #1;
        check("rst_count", count, 0);
        check("rst_busy_done", {busy, done}, 0);
        #12 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 4'hF);
        cycle(1, 5, 1, 4'hF);
        cycle(0, 0, 1, 4'b1011);
        cycle(0, 0, 1, 4'b0011);
        cycle(0, 0, 1, 4'b1001);
        cycle(0, 0, 1, 4'b0011);
        cycle(0, 0, 1, 4'b1011);
        check("basic_count", count, 32'h03_00_04_05);
        check("basic_run_max", run_max, 32'h01_00_02_05);
        cycle(0, 0, 1, 4'hF);
        cycle(1, 3, 0, 4'hF);
        for (int i = 0; i < 5; i++) cycle(0, 0, (i % 2) == 0, 4'hF);
        check("gap_done", 32'(done), 1);
        cycle(1, 4, 1, 4'hF);
        cycle(0, 0, 1, 4'hF);
        cycle(1, 9, 1, 4'hF);
        cycle(0, 0, 1, 4'hF);
        cycle(1, 9, 1, 4'hF);
        check("midstart_count", count, 32'h04_04_04_04);
        cycle(1, 2, 1, 4'h0);
        cycle(0, 0, 1, 4'h5);
        cycle(0, 0, 1, 4'hA);
        cycle(1, 0, 1, 4'hF);
        check("len0_done", {busy, done}, 1);
        cycle(0, 0, 1, 4'hF);
        cycle(1, 20, 0, 4'hF);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, 4'hF);
        check("sat_count", 32'(s_count[3:0]), 15);
        check("sat_ovf", 32'(s_ovf[0]), 1);
        check("sat_run_max", 32'(s_run_max[3:0]), 15);
        check("sat_done", 32'(s_done), 1);
        check("wrap_count", 32'(w_count[3:0]), 4);
        check("wrap_ovf", 32'(w_ovf[0]), 1);
        check("wrap_run_max", 32'(w_run_max[3:0]), 15);
        check("wrap_done", 32'(w_done), 1);
        cycle(1, 6, 0, 4'hF);
        cycle(0, 0, 1, 4'hF);
        cycle(0, 0, 1, 4'hF);
        rst_n = 1'b0;
        m_st = 0;
        model_clear();
        #1;
        check("async_count", count, 0);
        check("async_run_max", run_max, 0);
        check("async_busy_done", {busy, done}, 0);
        #2 rst_n = 1'b1;
        cycle(0, 0, 1, 4'hF);
        cycle(0, 0, 1, 4'hF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
